debug_ocimem_arbiter: RTL and testbench
=======================================

Name: debug_ocimem_arbiter

Overview:
- Sequences and shares the single-port on-chip debug memory (OCI RAM, 1-cycle read latency) of the Nios II debug module between two requesters.
- Requester J: the JTAG debug-slave command path (system-clock side). It issues single-cycle access pulses, uses an auto-incrementing address register, and returns data via MonDReg.
- Requester A: the CPU's Avalon debug_mem slave. It uses a waitrequest handshake.
- Ties are resolved round-robin. Access runs through a small FSM.

Parameters:
- ADDR_W, 8, OCI RAM word-address width; depth = 2^ADDR_W.
- DATA_W, 32, data width; byte lanes = DATA_W/8.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- jtag_set_addr  in  1  pulse: load MonAReg from jtag_addr.
- jtag_addr  in  ADDR_W  address for jtag_set_addr.
- jtag_req  in  1  pulse: request one J access at MonAReg.
- jtag_write  in  1  sampled with jtag_req: 1=write, 0=read.
- jtag_wdata  in  DATA_W  write data, sampled with jtag_req.
- jtag_clr_err  in  1  pulse: clear mon_error.
- mon_areg  out  ADDR_W  MonAReg, current J address.
- mon_dreg  out  DATA_W  MonDReg, last J read data.
- mon_ready  out  1  1 = no J access pending or in service.
- mon_error  out  1  sticky J protocol-error flag.
- av_read  in  1  Avalon read.
- av_write  in  1  Avalon write.
- av_address  in  ADDR_W  Avalon word address.
- av_writedata  in  DATA_W  Avalon write data.
- av_byteenable  in  DATA_W/8  Avalon byte enables.
- av_readdata  out  DATA_W  Avalon read data.
- av_waitrequest  out  1  Avalon stall.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_be  out  DATA_W/8  RAM byte enables.
- ram_we  out  1  RAM write strobe.
- ram_rdata  in  DATA_W  RAM read data, valid 1 cycle after address.

Behaviour:
- Reset values:
  - state=IDLE, mon_areg=0, mon_dreg=0, mon_ready=1, mon_error=0, j_pending=0, last_grant=A (so J wins the first tie).
  - ram_we=0; ram_addr, ram_wdata, ram_be driven 0.
  - av_readdata=0.
  - av_waitrequest = av_read|av_write (combinational; not granted).
- J capture:
  - jtag_req with j_pending=0 and state not serving J: set j_pending, latch jtag_write and jtag_wdata.
  - jtag_req while j_pending=1 or J in service: request dropped, mon_error<=1.
- Address:
  - jtag_set_addr while mon_ready=1: mon_areg<=jtag_addr.
  - jtag_set_addr while mon_ready=0: ignored, mon_error<=1.
- mon_error:
  - jtag_clr_err clears it.
  - If a set and a clear coincide, set wins.
- mon_ready = ~j_pending & state not in {SERV_J, CAPT_J}.
- FSM states: IDLE, SERV_J, CAPT_J, SERV_A, CAPT_A.
  - IDLE:
    - If only J requests (j_pending=1): go to SERV_J.
    - If only A requests (av_read|av_write): go to SERV_A.
    - If both: grant the requester ≠ last_grant.
    - On grant: last_grant<=granted requester; j_pending clears when J is granted.
  - SERV_J:
    - Drive ram_addr=mon_areg, ram_be=all ones.
    - Write: ram_we=1, ram_wdata=latched data; mon_areg<=mon_areg+1; go to IDLE.
    - Read: go to CAPT_J.
  - CAPT_J: mon_dreg<=ram_rdata; mon_areg<=mon_areg+1; go to IDLE.
  - SERV_A:
    - Drive ram_addr=av_address, ram_be=av_byteenable.
    - Write: ram_we=1, ram_wdata=av_writedata, av_waitrequest=0 this cycle; go to IDLE.
    - Read: go to CAPT_A.
  - CAPT_A: av_readdata=ram_rdata, av_waitrequest=0; go to IDLE.
- Latency from grant:
  - Write: 1 cycle after the IDLE grant cycle.
  - Read: 2 cycles after the IDLE grant cycle.
  - Minimum Avalon read: waitrequest high for 2 cycles, then readdata valid with waitrequest low.
- mon_areg increments mod 2^ADDR_W: all-ones wraps to 0.
- A jtag_req arriving in the same cycle J completes (end of SERV_J write or CAPT_J): accepted as new pending.
- A with both av_read and av_write asserted: treated as a write.
- A deasserting read/write before waitrequest falls: protocol violation, undefined.
- Reset asserted mid-operation: immediate return to reset values. A RAM write in progress is cut off and no completion is reported.

Test Plan:
- Load and write: jtag_set_addr with jtag_addr=0x10, then jtag_req write 0xDEADBEEF -> ram_we=1 with ram_addr=0x10, ram_wdata=0xDEADBEEF, ram_be=0xF; mon_areg=0x11; mon_ready returns to 1.
- J read: RAM[0x11]=0x12345678, jtag_req read -> ram_addr=0x11, then mon_dreg=0x12345678 on the following cycle; mon_areg=0x12.
- Simultaneous requests: jtag_req and av_read together, from reset -> J served first, then A. Repeating the tie -> A served first (round-robin alternates).
- Avalon write: av_write with av_address=0x03, byteenable=4'b0011 -> av_waitrequest high for 1 cycle, then ram_we=1 with ram_be=0x3 and waitrequest=0.
- Wrap and overrun: mon_areg=0xFF, J write -> mon_areg=0x00. A second jtag_req while J is pending -> mon_error=1; jtag_clr_err -> 0.
- Reset mid-read: reset asserted in SERV_A -> state=IDLE, ram_we=0, mon_ready=1; no spurious av_readdata.

Source files
------------

// File: rtl/debug_ocimem_arbiter.sv
// Shares the single-port OCI debug RAM between the JTAG monitor path (J)
// and the CPU's Avalon debug_mem slave (A), with round-robin tie-breaking.
module debug_ocimem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  jtag_set_addr,
    input  logic [ADDR_W-1:0]     jtag_addr,
    input  logic                  jtag_req,
    input  logic                  jtag_write,
    input  logic [DATA_W-1:0]     jtag_wdata,
    input  logic                  jtag_clr_err,
    output logic [ADDR_W-1:0]     mon_areg,
    output logic [DATA_W-1:0]     mon_dreg,
    output logic                  mon_ready,
    output logic                  mon_error,
    input  logic                  av_read,
    input  logic                  av_write,
    input  logic [ADDR_W-1:0]     av_address,
    input  logic [DATA_W-1:0]     av_writedata,
    input  logic [DATA_W/8-1:0]   av_byteenable,
    output logic [DATA_W-1:0]     av_readdata,
    output logic                  av_waitrequest,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [DATA_W-1:0]     ram_wdata,
    output logic [DATA_W/8-1:0]   ram_be,
    output logic                  ram_we,
    input  logic [DATA_W-1:0]     ram_rdata
);

    typedef enum logic [2:0] {IDLE, SERV_J, CAPT_J, SERV_A, CAPT_A} state_t;

    state_t              state;
    state_t              state_nxt;
    logic                j_pending;
    logic                j_write_q;
    logic [DATA_W-1:0]   j_wdata_q;
    logic                last_grant_a;

    logic a_req;
    logic j_in_service;
    logic j_complete;
    logic j_accept;
    logic err_set;
    logic grant_j;
    logic grant_a;

    assign a_req        = av_read | av_write;
    assign j_in_service = (state == SERV_J) || (state == CAPT_J);
    // A J access finishing this cycle frees the slot for a back-to-back request.
    assign j_complete   = ((state == SERV_J) && j_write_q) || (state == CAPT_J);
    assign j_accept     = jtag_req & ~j_pending & (~j_in_service | j_complete);
    assign mon_ready    = ~j_pending & ~j_in_service;
    assign err_set      = (jtag_req & ~j_accept) | (jtag_set_addr & ~mon_ready);

    assign grant_j = (state == IDLE) & j_pending & (~a_req | last_grant_a);
    assign grant_a = (state == IDLE) & a_req & (~j_pending | ~last_grant_a);

    always_comb begin
        state_nxt      = state;
        ram_addr       = '0;
        ram_wdata      = '0;
        ram_be         = '0;
        ram_we         = 1'b0;
        av_readdata    = '0;
        av_waitrequest = a_req;
        case (state)
            IDLE: begin
                if (grant_j) begin
                    state_nxt = SERV_J;
                end else if (grant_a) begin
                    state_nxt = SERV_A;
                end
            end
            SERV_J: begin
                ram_addr = mon_areg;
                ram_be   = '1;
                if (j_write_q) begin
                    ram_we    = 1'b1;
                    ram_wdata = j_wdata_q;
                    state_nxt = IDLE;
                end else begin
                    state_nxt = CAPT_J;
                end
            end
            CAPT_J: begin
                state_nxt = IDLE;
            end
            // A simultaneous read+write from the master is served as a write.
            SERV_A: begin
                ram_addr = av_address;
                ram_be   = av_byteenable;
                if (av_write) begin
                    ram_we         = 1'b1;
                    ram_wdata      = av_writedata;
                    av_waitrequest = 1'b0;
                    state_nxt      = IDLE;
                end else begin
                    state_nxt = CAPT_A;
                end
            end
            CAPT_A: begin
                av_readdata    = ram_rdata;
                av_waitrequest = 1'b0;
                state_nxt      = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            j_pending    <= 1'b0;
            j_write_q    <= 1'b0;
            j_wdata_q    <= '0;
            last_grant_a <= 1'b1;
            mon_areg     <= '0;
            mon_dreg     <= '0;
            mon_error    <= 1'b0;
        end else begin
            state <= state_nxt;

            if (grant_j) begin
                last_grant_a <= 1'b0;
            end else if (grant_a) begin
                last_grant_a <= 1'b1;
            end

            if (j_accept) begin
                j_pending <= 1'b1;
                j_write_q <= jtag_write;
                j_wdata_q <= jtag_wdata;
            end else if (grant_j) begin
                j_pending <= 1'b0;
            end

            if (j_complete) begin
                mon_areg <= mon_areg + 1'b1;
            end else if (jtag_set_addr && mon_ready) begin
                mon_areg <= jtag_addr;
            end

            if (state == CAPT_J) begin
                mon_dreg <= ram_rdata;
            end

            if (err_set) begin
                mon_error <= 1'b1;
            end else if (jtag_clr_err) begin
                mon_error <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_debug_ocimem_arbiter.sv
// Self-checking bench for debug_ocimem_arbiter: directed scenarios plus a
// randomized transaction phase checked against a shadow memory model.
module tb_debug_ocimem_arbiter;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic          clk;
    logic          reset;
    logic          jtag_set_addr;
    logic [AW-1:0] jtag_addr;
    logic          jtag_req;
    logic          jtag_write;
    logic [DW-1:0] jtag_wdata;
    logic          jtag_clr_err;
    logic [AW-1:0] mon_areg;
    logic [DW-1:0] mon_dreg;
    logic          mon_ready;
    logic          mon_error;
    logic          av_read;
    logic          av_write;
    logic [AW-1:0] av_address;
    logic [DW-1:0] av_writedata;
    logic [BW-1:0] av_byteenable;
    logic [DW-1:0] av_readdata;
    logic          av_waitrequest;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [BW-1:0] ram_be;
    logic          ram_we;
    logic [DW-1:0] ram_rdata;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] mem [256];
    logic [DW-1:0] exp_mem [256];
    bit            exp_valid [256];
    logic [AW-1:0] exp_areg;
    bit            model_last_j;

    debug_ocimem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk            (clk),
        .reset          (reset),
        .jtag_set_addr  (jtag_set_addr),
        .jtag_addr      (jtag_addr),
        .jtag_req       (jtag_req),
        .jtag_write     (jtag_write),
        .jtag_wdata     (jtag_wdata),
        .jtag_clr_err   (jtag_clr_err),
        .mon_areg       (mon_areg),
        .mon_dreg       (mon_dreg),
        .mon_ready      (mon_ready),
        .mon_error      (mon_error),
        .av_read        (av_read),
        .av_write       (av_write),
        .av_address     (av_address),
        .av_writedata   (av_writedata),
        .av_byteenable  (av_byteenable),
        .av_readdata    (av_readdata),
        .av_waitrequest (av_waitrequest),
        .ram_addr       (ram_addr),
        .ram_wdata      (ram_wdata),
        .ram_be         (ram_be),
        .ram_we         (ram_we),
        .ram_rdata      (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port RAM with byte lanes and one cycle of read latency.
    always @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < BW; b++) begin
                if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
        end
        ram_rdata <= mem[ram_addr];
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic set_addr(input logic [AW-1:0] a);
        jtag_set_addr = 1'b1;
        jtag_addr     = a;
        tick();
        jtag_set_addr = 1'b0;
    endtask

    task automatic wait_j_ready(output int cyc);
        cyc = 1;
        #1;
        while (!mon_ready && cyc < 12) begin
            tick();
            cyc++;
        end
        check_output("j_done", mon_ready, 1'b1);
    endtask

    task automatic j_op(input logic wr, input logic [DW-1:0] wd, output logic [DW-1:0] rd, output int cyc);
        jtag_req   = 1'b1;
        jtag_write = wr;
        jtag_wdata = wd;
        tick();
        jtag_req   = 1'b0;
        jtag_write = 1'b0;
        wait_j_ready(cyc);
        rd = mon_dreg;
    endtask

    task automatic av_op(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input logic [BW-1:0] be, output logic [DW-1:0] rd, output int waits);
        av_write      = wr;
        av_read       = ~wr;
        av_address    = a;
        av_writedata  = wd;
        av_byteenable = be;
        waits = 0;
        #1;
        while (av_waitrequest && waits < 12) begin
            tick();
            waits++;
        end
        check_output("av_done", av_waitrequest, 1'b0);
        rd = av_readdata;
        tick();
        av_read  = 1'b0;
        av_write = 1'b0;
    endtask

    // J write and A read contend in the same IDLE cycle; records service order by RAM address.
    task automatic tie_run(input logic [AW-1:0] ja, input logic [DW-1:0] jd, input logic [AW-1:0] aa,
                           output logic [AW-1:0] first, output logic [AW-1:0] second,
                           output logic [DW-1:0] ard);
        int  n;
        bit  a_done;
        set_addr(ja);
        jtag_req   = 1'b1;
        jtag_write = 1'b1;
        jtag_wdata = jd;
        tick();
        jtag_req      = 1'b0;
        jtag_write    = 1'b0;
        av_read       = 1'b1;
        av_address    = aa;
        av_byteenable = '1;
        a_done = 0;
        n      = 0;
        first  = '0;
        second = '0;
        ard    = '0;
        while (!(a_done && mon_ready) && n < 16) begin
            #1;
            if (ram_addr != '0) begin
                if (first == '0) first = ram_addr;
                else second = ram_addr;
            end
            if (av_read && !av_waitrequest) begin
                ard    = av_readdata;
                a_done = 1;
            end
            tick();
            n++;
            if (a_done) av_read = 1'b0;
        end
        check_output("tie_done", {63'd0, a_done && mon_ready}, 64'd1);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        model_last_j = 0;
    endtask

    initial begin
        logic [DW-1:0] rd;
        logic [AW-1:0] f;
        logic [AW-1:0] s;
        int            cyc;
        int            waits;

        reset = 1'b1;
        jtag_set_addr = 0; jtag_addr = '0; jtag_req = 0; jtag_write = 0;
        jtag_wdata = '0; jtag_clr_err = 0;
        av_read = 0; av_write = 0; av_address = '0; av_writedata = '0; av_byteenable = '0;
        model_last_j = 0;
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_areg", mon_areg, 0);
        check_output("rst_dreg", mon_dreg, 0);
        check_output("rst_ready", mon_ready, 1);
        check_output("rst_error", mon_error, 0);
        check_output("rst_we", ram_we, 0);
        check_output("rst_addr", ram_addr, 0);
        check_output("rst_wdata", ram_wdata, 0);
        check_output("rst_be", ram_be, 0);
        check_output("rst_rdata", av_readdata, 0);
        check_output("rst_waitreq_idle", av_waitrequest, 0);
        av_read = 1'b1;
        #1;
        check_output("rst_waitreq_req", av_waitrequest, 1);
        av_read = 1'b0;
        tick();
        reset = 1'b0;
        tick();

        $display("[TB] load and write");
        set_addr(8'h10);
        #1;
        check_output("load_areg", mon_areg, 8'h10);
        jtag_req = 1'b1; jtag_write = 1'b1; jtag_wdata = 32'hDEADBEEF;
        tick();
        jtag_req = 1'b0; jtag_write = 1'b0;
        #1;
        check_output("jw_grant_ready", mon_ready, 0);
        check_output("jw_grant_we", ram_we, 0);
        tick();
        check_output("jw_we", ram_we, 1);
        check_output("jw_addr", ram_addr, 8'h10);
        check_output("jw_wdata", ram_wdata, 32'hDEADBEEF);
        check_output("jw_be", ram_be, 4'hF);
        tick();
        check_output("jw_areg", mon_areg, 8'h11);
        check_output("jw_ready", mon_ready, 1);
        model_last_j = 1;

        av_op(1'b1, 8'h11, 32'h12345678, 4'hF, rd, waits);
        check_output("preload_waits", waits, 1);
        model_last_j = 0;

        $display("[TB] jtag read");
        jtag_req = 1'b1; jtag_write = 1'b0;
        tick();
        jtag_req = 1'b0;
        tick();
        check_output("jr_addr", ram_addr, 8'h11);
        check_output("jr_we", ram_we, 0);
        tick();
        tick();
        check_output("jr_dreg", mon_dreg, 32'h12345678);
        check_output("jr_areg", mon_areg, 8'h12);
        check_output("jr_ready", mon_ready, 1);
        model_last_j = 1;

        $display("[TB] avalon write");
        av_write = 1'b1; av_address = 8'h03; av_writedata = 32'hAABBCCDD; av_byteenable = 4'b0011;
        #1;
        check_output("aw_wait1", av_waitrequest, 1);
        check_output("aw_we0", ram_we, 0);
        tick();
        check_output("aw_we", ram_we, 1);
        check_output("aw_be", ram_be, 4'h3);
        check_output("aw_addr", ram_addr, 8'h03);
        check_output("aw_wdata", ram_wdata, 32'hAABBCCDD);
        check_output("aw_wait0", av_waitrequest, 0);
        tick();
        av_write = 1'b0;
        model_last_j = 0;

        av_op(1'b0, 8'h10, '0, 4'hF, rd, waits);
        check_output("ar_waits", waits, 2);
        check_output("ar_data", rd, 32'hDEADBEEF);

        $display("[TB] round robin");
        pulse_reset();
        tie_run(8'h20, 32'hCAFE0001, 8'h10, f, s, rd);
        check_output("tie1_first", f, model_last_j ? 8'h10 : 8'h20);
        check_output("tie1_second", s, model_last_j ? 8'h20 : 8'h10);
        check_output("tie1_rdata", rd, 32'hDEADBEEF);
        model_last_j = model_last_j ? 1'b1 : 1'b0;
        j_op(1'b1, 32'hCAFE0002, rd, cyc);
        check_output("rr_j_areg", mon_areg, 8'h22);
        model_last_j = 1;
        tie_run(8'h30, 32'hCAFE0003, 8'h20, f, s, rd);
        check_output("tie2_first", f, model_last_j ? 8'h20 : 8'h30);
        check_output("tie2_second", s, model_last_j ? 8'h30 : 8'h20);
        check_output("tie2_rdata", rd, 32'hCAFE0001);
        check_output("tie2_areg", mon_areg, 8'h31);

        $display("[TB] wrap and overrun");
        set_addr(8'hFF);
        j_op(1'b1, 32'h11111111, rd, cyc);
        check_output("wrap_areg", mon_areg, 8'h00);
        jtag_req = 1'b1; jtag_write = 1'b1; jtag_wdata = 32'h22222222;
        tick();
        jtag_wdata = 32'h33333333;
        tick();
        jtag_req = 1'b0; jtag_write = 1'b0;
        #1;
        check_output("ovr_error", mon_error, 1);
        wait_j_ready(cyc);
        check_output("ovr_areg", mon_areg, 8'h01);
        jtag_clr_err = 1'b1;
        tick();
        jtag_clr_err = 1'b0;
        #1;
        check_output("clr_error", mon_error, 0);
        jtag_req = 1'b1; jtag_write = 1'b1; jtag_wdata = 32'h44444444;
        tick();
        jtag_req = 1'b0; jtag_write = 1'b0;
        jtag_set_addr = 1'b1; jtag_addr = 8'h55; jtag_clr_err = 1'b1;
        tick();
        jtag_set_addr = 1'b0; jtag_clr_err = 1'b0;
        #1;
        check_output("setclr_error", mon_error, 1);
        wait_j_ready(cyc);
        check_output("busy_set_ignored", mon_areg, 8'h02);
        set_addr(8'h00);
        j_op(1'b0, '0, rd, cyc);
        check_output("ovr_mem0", rd, 32'h22222222);
        jtag_clr_err = 1'b1;
        tick();
        jtag_clr_err = 1'b0;

        $display("[TB] reset mid read");
        av_read = 1'b1; av_address = 8'h10; av_byteenable = 4'hF;
        tick();
        check_output("mid_serv_addr", ram_addr, 8'h10);
        reset = 1'b1;
        #1;
        check_output("mid_we", ram_we, 0);
        check_output("mid_addr", ram_addr, 0);
        check_output("mid_ready", mon_ready, 1);
        check_output("mid_rdata", av_readdata, 0);
        check_output("mid_dreg", mon_dreg, 0);
        av_read = 1'b0;
        tick();
        reset = 1'b0;
        model_last_j = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_output("post_rst_rdata", av_readdata, 0);
            check_output("post_rst_waitreq", av_waitrequest, 0);
        end

        $display("[TB] random phase");
        set_addr(8'h40);
        exp_areg = 8'h40;
        for (int i = 0; i < 16; i++) begin
            logic [DW-1:0] d;
            d = $urandom;
            j_op(1'b1, d, rd, cyc);
            exp_mem[exp_areg]   = d;
            exp_valid[exp_areg] = 1;
            exp_areg = exp_areg + 8'd1;
            check_output("fill_areg", mon_areg, exp_areg);
        end
        for (int i = 0; i < 60; i++) begin
            int            op;
            logic [DW-1:0] d;
            logic [AW-1:0] a;
            logic [BW-1:0] be;
            op = $urandom_range(0, 4);
            d  = $urandom;
            a  = 8'h40 + 8'($urandom_range(0, 15));
            be = 4'($urandom_range(1, 15));
            case (op)
                0: begin
                    set_addr(a);
                    exp_areg = a;
                    #1;
                    check_output("rnd_setaddr", mon_areg, exp_areg);
                end
                1: begin
                    j_op(1'b1, d, rd, cyc);
                    exp_mem[exp_areg]   = d;
                    exp_valid[exp_areg] = 1;
                    exp_areg = exp_areg + 8'd1;
                    check_output("rnd_jw_areg", mon_areg, exp_areg);
                    check_output("rnd_jw_cyc", cyc, 3);
                end
                2: begin
                    j_op(1'b0, '0, rd, cyc);
                    if (exp_valid[exp_areg]) check_output("rnd_jr_data", rd, exp_mem[exp_areg]);
                    exp_areg = exp_areg + 8'd1;
                    check_output("rnd_jr_areg", mon_areg, exp_areg);
                    check_output("rnd_jr_cyc", cyc, 4);
                end
                3: begin
                    av_op(1'b1, a, d, be, rd, waits);
                    for (int b = 0; b < BW; b++) begin
                        if (be[b]) exp_mem[a][8*b +: 8] = d[8*b +: 8];
                    end
                    check_output("rnd_aw_waits", waits, 1);
                end
                default: begin
                    av_op(1'b0, a, '0, 4'hF, rd, waits);
                    check_output("rnd_ar_data", rd, exp_mem[a]);
                    check_output("rnd_ar_waits", waits, 2);
                end
            endcase
        end
        check_output("rnd_error", mon_error, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
